// File: rtl/hetic_irq_sink_if.sv
// Controller/core-facing signal bundle for the HETI interrupt sink.
// The controller/core side drives through master; the sink uses slave.
interface hetic_irq_sink_if #(
   parameter int NrIrqLines = 64,
   parameter int NrIrqPrios = 32,
   parameter int NestDepth  = 4
);
   localparam int IrqWidth   = $clog2(NrIrqLines);
   localparam int PrioWidth  = $clog2(NrIrqPrios);
   localparam int DepthWidth = $clog2(NestDepth + 1);

   logic                  irq_valid_i;
   logic [IrqWidth-1:0]   irq_id_i;
   logic [PrioWidth-1:0]  irq_level_i;
   logic                  irq_heti_i;
   logic                  irq_nest_i;
   logic                  irq_ack_o;
   logic [IrqWidth-1:0]   irq_ack_id_o;
   logic                  mie_i;
   logic                  core_irq_req_o;
   logic [IrqWidth-1:0]   core_irq_id_o;
   logic                  core_irq_heti_o;
   logic                  core_take_i;
   logic                  core_mret_i;
   logic [PrioWidth-1:0]  cur_level_o;
   logic [DepthWidth-1:0] depth_o;

   modport master (
      output irq_valid_i, irq_id_i, irq_level_i, irq_heti_i,
      output irq_nest_i, mie_i, core_take_i, core_mret_i,
      input  irq_ack_o, irq_ack_id_o, core_irq_req_o,
      input  core_irq_id_o, core_irq_heti_o, cur_level_o, depth_o
   );

   modport slave (
      input  irq_valid_i, irq_id_i, irq_level_i, irq_heti_i,
      input  irq_nest_i, mie_i, core_take_i, core_mret_i,
      output irq_ack_o, irq_ack_id_o, core_irq_req_o,
      output core_irq_id_o, core_irq_heti_o, cur_level_o, depth_o
   );
endinterface

// File: rtl/hetic_irq_sink.sv
// Core-side interrupt sink: qualifies the controller winner, offers it
// to the core, returns the claim and tracks nested handler levels.
module hetic_irq_sink #(
   parameter int NrIrqLines = 64,
   parameter int NrIrqPrios = 32,
   parameter int NestDepth  = 4
) (
   input logic             clk_i,
   input logic             rst_ni,
   hetic_irq_sink_if.slave irq_if
);
   localparam int IrqWidth   = $clog2(NrIrqLines);
   localparam int PrioWidth  = $clog2(NrIrqPrios);
   localparam int DepthWidth = $clog2(NestDepth + 1);
   localparam int IdxWidth   = (NestDepth > 1) ? $clog2(NestDepth) : 1;

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      ACK,
      SETTLE
   } state_e;

   state_e state_q, state_d;

   logic [IrqWidth-1:0]   cand_id_q, cand_id_d;
   logic [PrioWidth-1:0]  cand_lvl_q, cand_lvl_d;
   logic                  cand_heti_q, cand_heti_d;

   logic [PrioWidth-1:0]  stk_lvl_q [NestDepth];
   logic [DepthWidth-1:0] depth_q, depth_d;

   logic [PrioWidth-1:0]  cur_level;
   logic [IdxWidth-1:0]   top_idx;
   logic [IdxWidth-1:0]   wr_idx;
   logic [DepthWidth-1:0] depth_pop;
   logic                  eligible;
   logic                  take;
   logic                  pop;
   logic                  push;
   logic                  req;
   logic                  ack;

   assign top_idx   = IdxWidth'(depth_q - 1'b1);
   assign cur_level = (depth_q == '0) ? '0 : stk_lvl_q[top_idx];

   assign eligible = irq_if.irq_valid_i & irq_if.mie_i
                   & (irq_if.irq_level_i > cur_level)
                   & ((depth_q == '0)
                   | (irq_if.irq_nest_i
                   & (depth_q < DepthWidth'(NestDepth))));

   assign take = (state_q == OFFER) & irq_if.core_take_i;
   assign pop  = irq_if.core_mret_i & (depth_q != '0);

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      ack     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (eligible) state_d = OFFER;
         end
         OFFER: begin
            req = 1'b1;
            // A take wins even if eligibility drops in the same cycle.
            if (take)           state_d = ACK;
            else if (!eligible) state_d = IDLE;
         end
         ACK: begin
            ack     = 1'b1;
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cand_id_d   = cand_id_q;
      cand_lvl_d  = cand_lvl_q;
      cand_heti_d = cand_heti_q;
      if ((state_q == IDLE) || (state_q == OFFER)) begin
         cand_id_d   = irq_if.irq_id_i;
         cand_lvl_d  = irq_if.irq_level_i;
         cand_heti_d = irq_if.irq_heti_i;
      end
   end

   // Pop before push so a same-cycle take+mret replaces the top.
   always_comb begin
      depth_pop = depth_q - DepthWidth'(pop);
      push      = take & (depth_pop < DepthWidth'(NestDepth));
      wr_idx    = IdxWidth'(depth_pop);
      depth_d   = depth_pop + DepthWidth'(push);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cand_id_q   <= '0;
         cand_lvl_q  <= '0;
         cand_heti_q <= 1'b0;
         depth_q     <= '0;
      end else begin
         state_q     <= state_d;
         cand_id_q   <= cand_id_d;
         cand_lvl_q  <= cand_lvl_d;
         cand_heti_q <= cand_heti_d;
         depth_q     <= depth_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NestDepth; i++) stk_lvl_q[i] <= '0;
      end else if (push) begin
         stk_lvl_q[wr_idx] <= cand_lvl_q;
      end
   end

   assign irq_if.core_irq_req_o  = req;
   assign irq_if.core_irq_id_o   = req ? cand_id_q : '0;
   assign irq_if.core_irq_heti_o = req & cand_heti_q;
   assign irq_if.irq_ack_o       = ack;
   assign irq_if.irq_ack_id_o    = ack ? cand_id_q : '0;
   assign irq_if.cur_level_o     = cur_level;
   assign irq_if.depth_o         = depth_q;
endmodule

// File: tb/tb_hetic_irq_sink.sv
// Directed self-checking bench for hetic_irq_sink.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_hetic_irq_sink;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   hetic_irq_sink_if bus ();

   hetic_irq_sink dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .irq_if(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int id, input int lvl, input logic nest);
      bus.irq_valid_i = 1'b1;
      bus.irq_id_i    = 6'(id);
      bus.irq_level_i = 5'(lvl);
      bus.irq_nest_i  = nest;
   endtask

   // Offer, take, then let ACK and SETTLE run back to IDLE.
   task automatic push_lvl(input int id, input int lvl, input int dep);
      offer(id, lvl, 1'b1);
      tick();
      chk("push_req", 32'(bus.core_irq_req_o), 1);
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.irq_valid_i = 1'b0;
      chk("push_ack_id", 32'(bus.irq_ack_id_o), 32'(id));
      chk("push_depth", 32'(bus.depth_o), 32'(dep));
      chk("push_cur", 32'(bus.cur_level_o), 32'(lvl));
      tick();
      tick();
   endtask

   initial begin
      int exp_d[5];
      int exp_l[5];
      exp_d = '{3, 2, 1, 0, 0};
      exp_l = '{6, 4, 2, 0, 0};
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus.irq_valid_i = 1'b0;
      bus.irq_id_i    = '0;
      bus.irq_level_i = '0;
      bus.irq_heti_i  = 1'b0;
      bus.irq_nest_i  = 1'b0;
      bus.mie_i       = 1'b1;
      bus.core_take_i = 1'b0;
      bus.core_mret_i = 1'b0;
      #3;
      chk("rst_req", 32'(bus.core_irq_req_o), 0);
      chk("rst_ack", 32'(bus.irq_ack_o), 0);
      chk("rst_depth", 32'(bus.depth_o), 0);
      chk("rst_cur", 32'(bus.cur_level_o), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Asynchronous reset while id 5 is on offer
      offer(5, 2, 1'b0);
      tick();
      chk("mid_req", 32'(bus.core_irq_req_o), 1);
      chk("mid_id", 32'(bus.core_irq_id_o), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(bus.core_irq_req_o), 0);
      chk("arst_ack", 32'(bus.irq_ack_o), 0);
      chk("arst_depth", 32'(bus.depth_o), 0);
      chk("arst_cur", 32'(bus.cur_level_o), 0);
      chk("arst_id", 32'(bus.core_irq_id_o), 0);
      rst_n = 1'b1;
      bus.irq_valid_i = 1'b0;
      tick();
      chk("post_rst_req", 32'(bus.core_irq_req_o), 0);

      // Basic offer and claim
      offer(7, 3, 1'b0);
      bus.irq_heti_i = 1'b1;
      tick();
      chk("basic_req", 32'(bus.core_irq_req_o), 1);
      chk("basic_id", 32'(bus.core_irq_id_o), 7);
      chk("basic_heti", 32'(bus.core_irq_heti_o), 1);
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.irq_heti_i  = 1'b0;
      chk("basic_ack", 32'(bus.irq_ack_o), 1);
      chk("basic_ack_id", 32'(bus.irq_ack_id_o), 7);
      chk("basic_ack_req", 32'(bus.core_irq_req_o), 0);
      chk("basic_depth", 32'(bus.depth_o), 1);
      chk("basic_cur", 32'(bus.cur_level_o), 3);
      tick();
      chk("settle_ack", 32'(bus.irq_ack_o), 0);
      chk("settle_req", 32'(bus.core_irq_req_o), 0);
      tick();
      tick();
      chk("equal_lvl_req", 32'(bus.core_irq_req_o), 0);

      // Preemption with nest=1
      offer(9, 5, 1'b1);
      tick();
      chk("pre_req", 32'(bus.core_irq_req_o), 1);
      chk("pre_id", 32'(bus.core_irq_id_o), 9);
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.irq_valid_i = 1'b0;
      chk("pre_ack_id", 32'(bus.irq_ack_id_o), 9);
      chk("pre_depth", 32'(bus.depth_o), 2);
      chk("pre_cur", 32'(bus.cur_level_o), 5);
      tick();
      tick();
      bus.core_mret_i = 1'b1;
      tick();
      bus.core_mret_i = 1'b0;
      chk("pre_pop_depth", 32'(bus.depth_o), 1);
      chk("pre_pop_cur", 32'(bus.cur_level_o), 3);
      offer(9, 5, 1'b0);
      tick();
      tick();
      chk("no_nest_req", 32'(bus.core_irq_req_o), 0);
      offer(9, 3, 1'b1);
      tick();
      tick();
      chk("eq_nest_req", 32'(bus.core_irq_req_o), 0);

      // Higher winner replaces the pending offer
      offer(2, 4, 1'b1);
      tick();
      chk("repl_first_id", 32'(bus.core_irq_id_o), 2);
      offer(11, 6, 1'b1);
      tick();
      chk("repl_req", 32'(bus.core_irq_req_o), 1);
      chk("repl_id", 32'(bus.core_irq_id_o), 11);
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.irq_valid_i = 1'b0;
      chk("repl_ack_id", 32'(bus.irq_ack_id_o), 11);
      chk("repl_cur", 32'(bus.cur_level_o), 6);
      tick();
      tick();
      bus.core_mret_i = 1'b1;
      tick();
      tick();
      bus.core_mret_i = 1'b0;
      chk("drain_depth", 32'(bus.depth_o), 0);

      // Take while nothing is offered is ignored
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      chk("idle_take_ack", 32'(bus.irq_ack_o), 0);
      chk("idle_take_depth", 32'(bus.depth_o), 0);

      // mie falling during an offer withdraws it
      offer(4, 2, 1'b0);
      tick();
      chk("mie_req", 32'(bus.core_irq_req_o), 1);
      bus.mie_i = 1'b0;
      tick();
      chk("mie_off_req", 32'(bus.core_irq_req_o), 0);
      bus.mie_i = 1'b1;
      tick();
      chk("mie_back_req", 32'(bus.core_irq_req_o), 1);
      bus.mie_i       = 1'b0;
      bus.core_take_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.mie_i       = 1'b1;
      bus.irq_valid_i = 1'b0;
      chk("mie_take_ack", 32'(bus.irq_ack_o), 1);
      chk("mie_take_depth", 32'(bus.depth_o), 1);
      tick();
      tick();
      bus.core_mret_i = 1'b1;
      tick();
      bus.core_mret_i = 1'b0;

      // Fill the stack, then underflow it
      push_lvl(1, 2, 1);
      push_lvl(2, 4, 2);
      push_lvl(3, 6, 3);
      push_lvl(4, 8, 4);
      offer(20, 10, 1'b1);
      tick();
      tick();
      chk("full_req", 32'(bus.core_irq_req_o), 0);
      bus.irq_valid_i = 1'b0;
      bus.core_mret_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("pop_depth", 32'(bus.depth_o), 32'(exp_d[i]));
         chk("pop_cur", 32'(bus.cur_level_o), 32'(exp_l[i]));
      end
      bus.core_mret_i = 1'b0;

      // Same-cycle take and mret replace the top entry
      push_lvl(8, 3, 1);
      offer(12, 5, 1'b1);
      tick();
      chk("sim_req", 32'(bus.core_irq_req_o), 1);
      bus.core_take_i = 1'b1;
      bus.core_mret_i = 1'b1;
      tick();
      bus.core_take_i = 1'b0;
      bus.core_mret_i = 1'b0;
      bus.irq_valid_i = 1'b0;
      chk("sim_ack", 32'(bus.irq_ack_o), 1);
      chk("sim_ack_id", 32'(bus.irq_ack_id_o), 12);
      chk("sim_depth", 32'(bus.depth_o), 1);
      chk("sim_cur", 32'(bus.cur_level_o), 5);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
